// File: rtl/mest_pro_seq.sv
`default_nettype none
// ============================================================================
// Module      : mest_pro_seq
// Description : MESTPro fetch/issue sequencer with PC and return-address stack.
//               Define MEST_PRO_SINGLE_STEP_EN to add i_step and a STEP state.
// Revision    : 1.0 - initial release
// ============================================================================
module mest_pro_seq #(
    parameter int OPCODE_W    = 5,
    parameter int OPA_W       = 8,
    parameter int OPB_W       = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            i_reset,
    input  logic                            i_start,
`ifdef MEST_PRO_SINGLE_STEP_EN
    input  logic                            i_step,
`endif
    output logic                            o_imem_req,
    output logic [PC_W-1:0]                 o_imem_addr,
    input  logic                            i_imem_ack,
    input  logic [OPCODE_W+OPA_W+OPB_W-1:0] i_imem_data,
    output logic                            o_execute,
    output logic [OPCODE_W-1:0]             o_op_code,
    output logic [OPA_W-1:0]                o_operand1,
    output logic [OPB_W-1:0]                o_operand2,
    input  logic                            i_exec_done,
    input  logic                            i_jump,
    input  logic                            i_return_pc,
    input  logic                            i_end_of_code,
    output logic [PC_W-1:0]                 o_pc,
    output logic                            o_busy,
    output logic                            o_halted,
    output logic                            o_stack_err
);

    localparam int c_IDX_W = $clog2(STACK_DEPTH);
    localparam int c_SP_W  = c_IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
`ifdef MEST_PRO_SINGLE_STEP_EN
        S_HALTED = 3'd4,
        S_STEP   = 3'd5
`else
        S_HALTED = 3'd4
`endif
    } state_t;

    state_t             r_state;
    logic [c_SP_W-1:0]  r_sp;
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];

    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_jump_target;
    logic [PC_W-1:0]    w_next_pc;
    logic [c_SP_W-1:0]  w_sp_dec;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_err;

    // Jump target is the low PC_W bits of operand B, zero-extended if narrower.
    generate
        if (PC_W <= OPB_W) begin : g_tgt_trunc
            assign w_jump_target = o_operand2[PC_W-1:0];
        end else begin : g_tgt_ext
            assign w_jump_target = {{(PC_W-OPB_W){1'b0}}, o_operand2};
        end
    endgenerate

    assign w_pc_inc = o_pc + 1'b1;
    assign w_sp_dec = r_sp - 1'b1;
    assign w_full   = (r_sp == c_SP_W'(STACK_DEPTH));
    assign w_empty  = (r_sp == '0);

    // Flow-control decision for a completed instruction; end_of_code is
    // handled ahead of this in the state machine.
    always_comb begin
        w_next_pc = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err     = 1'b0;
        if (i_return_pc) begin
            if (w_empty) begin
                w_err = 1'b1;
            end else begin
                w_pop     = 1'b1;
                w_next_pc = r_stack[w_sp_dec[c_IDX_W-1:0]];
            end
        end else if (i_jump) begin
            w_next_pc = w_jump_target;
            if (w_full) begin
                w_err = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_sp        <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            o_pc        <= '0;
            o_imem_req  <= 1'b0;
            o_imem_addr <= '0;
            o_execute   <= 1'b0;
            o_op_code   <= '0;
            o_operand1  <= '0;
            o_operand2  <= '0;
            o_busy      <= 1'b0;
            o_halted    <= 1'b0;
            o_stack_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (i_start) begin
                        r_state     <= S_FETCH;
                        r_sp        <= '0;
                        o_pc        <= '0;
                        o_stack_err <= 1'b0;
                        o_halted    <= 1'b0;
                        o_busy      <= 1'b1;
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= '0;
                    end
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        {o_op_code, o_operand1, o_operand2} <= i_imem_data;
                        o_imem_req <= 1'b0;
                        o_execute  <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_execute <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_exec_done) begin
                        if (i_end_of_code) begin
                            r_state  <= S_HALTED;
                            o_busy   <= 1'b0;
                            o_halted <= 1'b1;
                        end else begin
                            o_pc <= w_next_pc;
                            if (w_push) begin
                                r_stack[r_sp[c_IDX_W-1:0]] <= w_pc_inc;
                                r_sp <= r_sp + 1'b1;
                            end
                            if (w_pop) begin
                                r_sp <= w_sp_dec;
                            end
                            if (w_err) begin
                                o_stack_err <= 1'b1;
                            end
`ifdef MEST_PRO_SINGLE_STEP_EN
                            r_state <= S_STEP;
                            o_busy  <= 1'b0;
`else
                            r_state     <= S_FETCH;
                            o_imem_req  <= 1'b1;
                            o_imem_addr <= w_next_pc;
`endif
                        end
                    end
                end
`ifdef MEST_PRO_SINGLE_STEP_EN
                S_STEP: begin
                    if (i_step) begin
                        r_state     <= S_FETCH;
                        o_busy      <= 1'b1;
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= o_pc;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mest_pro_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mest_pro_seq
// Description : Directed self-checking bench for the mest_pro_seq sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mest_pro_seq;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [20:0] i_imem_data;
    logic        o_execute;
    logic [4:0]  o_op_code;
    logic [7:0]  o_operand1;
    logic [7:0]  o_operand2;
    logic        i_exec_done;
    logic        i_jump;
    logic        i_return_pc;
    logic        i_end_of_code;
    logic [7:0]  o_pc;
    logic        o_busy;
    logic        o_halted;
    logic        o_stack_err;
`ifdef MEST_PRO_SINGLE_STEP_EN
    logic        i_step;
    assign i_step = 1'b1;
`endif

    int total = 0;
    int bad   = 0;
    int exec_cnt = 0;
    int base;

    localparam logic [4:0] c_NOP = 5'h01;
    localparam logic [4:0] c_JMP = 5'h02;
    localparam logic [4:0] c_RET = 5'h03;
    localparam logic [4:0] c_END = 5'h1F;

    mest_pro_seq dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
`ifdef MEST_PRO_SINGLE_STEP_EN
        .i_step       (i_step),
`endif
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_data  (i_imem_data),
        .o_execute    (o_execute),
        .o_op_code    (o_op_code),
        .o_operand1   (o_operand1),
        .o_operand2   (o_operand2),
        .i_exec_done  (i_exec_done),
        .i_jump       (i_jump),
        .i_return_pc  (i_return_pc),
        .i_end_of_code(i_end_of_code),
        .o_pc         (o_pc),
        .o_busy       (o_busy),
        .o_halted     (o_halted),
        .o_stack_err  (o_stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_execute === 1'b1) exec_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    32'(o_imem_req),  0);
        check({tag, "_addr"},   32'(o_imem_addr), 0);
        check({tag, "_exec"},   32'(o_execute),   0);
        check({tag, "_fields"}, 32'({o_op_code, o_operand1, o_operand2}), 0);
        check({tag, "_pc"},     32'(o_pc),        0);
        check({tag, "_busy"},   32'(o_busy),      0);
        check({tag, "_halted"}, 32'(o_halted),    0);
        check({tag, "_err"},    32'(o_stack_err), 0);
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_busy",   32'(o_busy),      1);
        check("start_halted", 32'(o_halted),    0);
        check("start_err",    32'(o_stack_err), 0);
        check("start_pc",     32'(o_pc),        0);
    endtask

    // One full fetch/issue/complete cycle with optional ack stall; during the
    // stall exec_done+end_of_code are driven to show they are ignored in FETCH.
    task automatic do_instr(input logic [7:0] exp_addr, input logic [20:0] instr,
                            input int ack_dly, input logic jmp, input logic ret,
                            input logic eoc);
        int n;
        logic [20:0] held;
        n = 0;
        while (o_imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen",   32'(o_imem_req),  1);
        check("fetch_addr", 32'(o_imem_addr), 32'(exp_addr));
        held = {o_op_code, o_operand1, o_operand2};
        for (int i = 0; i < ack_dly; i++) begin
            i_exec_done   = 1'b1;
            i_end_of_code = 1'b1;
            tick();
            check("stall_req",    32'(o_imem_req), 1);
            check("stall_fields", 32'({o_op_code, o_operand1, o_operand2}), 32'(held));
        end
        i_exec_done   = 1'b0;
        i_end_of_code = 1'b0;
        i_imem_ack    = 1'b1;
        i_imem_data   = instr;
        tick();
        i_imem_ack  = 1'b0;
        i_imem_data = '0;
        check("issue_pulse",  32'(o_execute),  1);
        check("issue_reqoff", 32'(o_imem_req), 0);
        check("issue_fields", 32'({o_op_code, o_operand1, o_operand2}), 32'(instr));
        tick();
        check("issue_once",  32'(o_execute), 0);
        check("wait_fields", 32'({o_op_code, o_operand1, o_operand2}), 32'(instr));
        i_exec_done   = 1'b1;
        i_jump        = jmp;
        i_return_pc   = ret;
        i_end_of_code = eoc;
        tick();
        i_exec_done   = 1'b0;
        i_jump        = 1'b0;
        i_return_pc   = 1'b0;
        i_end_of_code = 1'b0;
    endtask

    initial begin
        i_reset       = 1'b1;
        i_start       = 1'b0;
        i_imem_ack    = 1'b0;
        i_imem_data   = '0;
        i_exec_done   = 1'b0;
        i_jump        = 1'b0;
        i_return_pc   = 1'b0;
        i_end_of_code = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        i_reset = 1'b0;
        tick();
        check("idle_noreq", 32'(o_imem_req), 0);

        // Sequential run ending in HALT at address 3
        base = exec_cnt;
        start_run();
        do_instr(8'h00, {c_NOP, 8'h10, 8'h20}, 0, 1'b0, 1'b0, 1'b0);
        do_instr(8'h01, {c_NOP, 8'h11, 8'h21}, 0, 1'b0, 1'b0, 1'b0);
        do_instr(8'h02, {c_NOP, 8'h12, 8'h22}, 0, 1'b0, 1'b0, 1'b0);
        do_instr(8'h03, {c_END, 8'h13, 8'h23}, 0, 1'b0, 1'b0, 1'b1);
        check("seq_halted",  32'(o_halted),   1);
        check("seq_busy",    32'(o_busy),     0);
        check("seq_pc",      32'(o_pc),       3);
        check("seq_execs",   32'(exec_cnt - base), 4);
        check("seq_noreq",   32'(o_imem_req), 0);

        // Call at 5 to 0x20, return to 6, then underflow at 6
        start_run();
        for (int i = 0; i < 5; i++) begin
            do_instr(8'(i), {c_NOP, 8'h00, 8'h00}, 0, 1'b0, 1'b0, 1'b0);
        end
        do_instr(8'h05, {c_JMP, 8'h00, 8'h20}, 0, 1'b1, 1'b0, 1'b0);
        check("call_pc", 32'(o_pc), 32'h20);
        do_instr(8'h20, {c_RET, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1'b0);
        check("ret_pc",  32'(o_pc), 6);
        check("ret_err", 32'(o_stack_err), 0);
        do_instr(8'h06, {c_RET, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1'b0);
        check("under_err", 32'(o_stack_err), 1);
        check("under_pc",  32'(o_pc), 7);
        do_instr(8'h07, {c_END, 8'h00, 8'h00}, 0, 1'b0, 1'b0, 1'b1);
        check("under_halt", 32'(o_halted), 1);

        // Five nested calls overflow a 4-deep stack; fifth jump still taken
        start_run();
        do_instr(8'h00, {c_JMP, 8'h00, 8'h10}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'h10, {c_JMP, 8'h00, 8'h20}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'h20, {c_JMP, 8'h00, 8'h30}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'h30, {c_JMP, 8'h00, 8'h40}, 0, 1'b1, 1'b0, 1'b0);
        check("full_err0", 32'(o_stack_err), 0);
        do_instr(8'h40, {c_JMP, 8'h00, 8'h50}, 0, 1'b1, 1'b0, 1'b0);
        check("over_err", 32'(o_stack_err), 1);
        do_instr(8'h50, {c_RET, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1'b0);
        do_instr(8'h31, {c_END, 8'h00, 8'h00}, 0, 1'b0, 1'b0, 1'b1);
        check("over_pc", 32'(o_pc), 32'h31);

        // PC and pushed return address wrap past 0xFF
        start_run();
        do_instr(8'h00, {c_JMP, 8'h00, 8'hFF}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'hFF, {c_NOP, 8'h00, 8'h00}, 0, 1'b0, 1'b0, 1'b0);
        check("wrap_pc", 32'(o_pc), 0);
        do_instr(8'h00, {c_JMP, 8'h00, 8'hFF}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'hFF, {c_JMP, 8'h00, 8'h40}, 0, 1'b1, 1'b0, 1'b0);
        do_instr(8'h40, {c_RET, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1'b0);
        check("wrap_ret", 32'(o_pc), 0);

        // end_of_code beats jump; fetch stalls 3 cycles on ack
        do_instr(8'h00, {c_JMP, 8'hAA, 8'h55}, 3, 1'b1, 1'b0, 1'b1);
        check("prio_halt", 32'(o_halted), 1);
        check("prio_pc",   32'(o_pc), 0);
        check("prio_err",  32'(o_stack_err), 0);

        // Asynchronous reset in WAIT abandons the instruction
        start_run();
        i_imem_ack  = 1'b1;
        i_imem_data = {c_NOP, 8'h77, 8'h66};
        tick();
        i_imem_ack  = 1'b0;
        i_imem_data = '0;
        tick();
        #2;
        i_reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        base = exec_cnt;
        tick();
        i_reset = 1'b0;
        tick();
        tick();
        check("rst_noexec", 32'(exec_cnt - base), 0);
        check("rst_noreq",  32'(o_imem_req), 0);
        start_run();
        do_instr(8'h00, {c_END, 8'h00, 8'h00}, 0, 1'b0, 1'b0, 1'b1);
        check("rst_halt", 32'(o_halted), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mest_pro_seq.md
Name: mest_pro_seq

Overview:
- Fetch/issue sequencer for the MESTPro execute unit.
- Fetches instructions from instruction memory via a req/ack handshake and holds the decoded fields stable to the exec unit.
- Pulses the exec unit's execute input, waits for its exec-done, then updates the PC from the exec unit's jump/return/end-of-code flags.
- Owns the PC and a small return-address stack. Sits between instruction memory and the exec unit.

Parameters:
- OPCODE_W, 5, opcode field width (matches `OPCODE_SIZE)
- OPA_W, 8, operand A width (matches `OPERANDA_SIZE)
- OPB_W, 8, operand B width (matches `OPERANDB_SIZE)
- PC_W, 8, program counter width
- STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; honoured only in IDLE or HALTED
- o_imem_req  out  1  fetch request
- o_imem_addr  out  PC_W  fetch address (= PC)
- i_imem_ack  in  1  fetch data valid
- i_imem_data  in  OPCODE_W+OPA_W+OPB_W  instruction {opcode, opA, opB}, MSB first
- o_execute  out  1  one-cycle issue pulse to exec unit
- o_op_code  out  OPCODE_W  held opcode
- o_operand1  out  OPA_W  held operand A
- o_operand2  out  OPB_W  held operand B
- i_exec_done  in  1  exec unit completion
- i_jump  in  1  exec jump flag
- i_return_pc  in  1  exec return flag
- i_end_of_code  in  1  exec halt flag
- o_pc  out  PC_W  current PC
- o_busy  out  1  high in FETCH/ISSUE/WAIT
- o_halted  out  1  high in HALTED
- o_stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, i_reset=1): state=IDLE. PC, stack pointer, o_imem_addr, o_op_code and both operands = 0. o_imem_req, o_execute, o_busy, o_halted and o_stack_err = 0. Reset mid-fetch or mid-wait abandons the operation; no exec issue follows.
- States: IDLE, FETCH, ISSUE, WAIT, HALTED. All outputs are registered.
- IDLE: when i_start=1, clear PC, stack pointer and o_stack_err, then go to FETCH.
- FETCH: o_imem_req=1 and o_imem_addr=PC, held until i_imem_ack. On ack (same cycle), latch i_imem_data into o_op_code/o_operand1/o_operand2, drop o_imem_req, go to ISSUE. Minimum 1 cycle; no timeout.
- ISSUE: o_execute=1 for exactly one cycle, then go to WAIT. The held fields stay stable until the next fetch ack.
- WAIT: ignore the flags until i_exec_done=1, then sample them in that cycle. Priority is end_of_code > return_pc > jump > sequential:
  - end_of_code: go to HALTED; PC unchanged.
  - return_pc, stack non-empty: pop; PC = popped value. Stack empty: set o_stack_err, PC = PC+1.
  - jump: push PC+1 (wraps), PC = o_operand2[PC_W-1:0]. Stack full: no push, set o_stack_err, jump still taken.
  - none: PC = PC+1.
  - Then go to FETCH (next cycle).
- PC arithmetic is modulo 2^PC_W; 2^PC_W-1 increments to 0 with no flag. A pushed return address wraps the same way.
- HALTED: o_halted=1, o_busy=0. i_start behaves as in IDLE and clears o_halted.
- i_start outside IDLE/HALTED is ignored.
- i_exec_done asserted in FETCH or ISSUE is ignored.
- Instruction latency: fetch (>=1) + issue (1) + exec-done wait (>=1) + 0. Best-case throughput is 1 instruction per 3 cycles plus exec latency.

Optional Feature:
- Macro: MEST_PRO_SINGLE_STEP_EN.
- Defined:
  - Adds port i_step (in, 1) and state STEP.
  - WAIT completion goes to STEP instead of FETCH; the PC is updated as normal.
  - STEP holds, with o_busy=0, until i_step=1, then goes to FETCH.
  - end_of_code still goes directly to HALTED.
  - i_start in STEP is ignored.
- Not defined: i_step port and STEP state are absent; free-running sequencing.

Test Plan:
- Sequential run: reset, i_start. Imem returns non-jump ops at 0,1,2, then HALT at 3 with 0-cycle ack delay and exec done 1 cycle after issue -> o_imem_addr 0,1,2,3; four o_execute pulses; o_halted=1; o_pc=3.
- Call/return: JMP opB=0x20 at PC 5, RET at 0x20 -> next fetches at 0x20, then 6; stack empty afterwards; o_stack_err=0.
- Overflow: STACK_DEPTH=4, five nested JMPs -> fifth jump still taken, o_stack_err=1. Underflow: RET with empty stack -> PC+1, o_stack_err=1.
- Wrap: JMP to 0xFF, non-jump op there -> next fetch at 0x00. JMP at 0xFF pushes 0x00.
- Priority and stalls: i_jump and i_end_of_code together with done -> HALTED, no push. i_imem_ack delayed 3 cycles -> o_imem_req held 3 cycles, operands unchanged until ack.
- Reset mid-WAIT, then i_start -> all outputs 0, fetch restarts at 0, no stray o_execute. With MEST_PRO_SINGLE_STEP_EN, no fetch occurs until i_step.
